// File: rtl/router_pkg.sv
// Shared router constants: port geometry, buffer sizing, port encodings and
// the per-output allocator state type.
package router_pkg;
  localparam int NUM_IN    = 5;
  localparam int NUM_OUT   = 5;
  localparam int PORT_W    = 3;
  localparam int BUF_DEPTH = 4;
  localparam int CRED_W    = 3;

  localparam logic [PORT_W-1:0] LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] NORTH = 3'd1;
  localparam logic [PORT_W-1:0] EAST  = 3'd2;
  localparam logic [PORT_W-1:0] SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] WEST  = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_t;
endpackage

// File: rtl/router_switch_alloc_if.sv
// Request/grant bundle between route computation, the switch allocator and
// the crossbar, plus read-only allocator state for observation.
interface router_switch_alloc_if;
  import router_pkg::*;

  // Handshake: input i offers a flit while req_valid[i]=1 and keeps req_* stable
  // until grant[i]=1; the flit is consumed on the rising edge ending that cycle.
  logic [NUM_IN-1:0]         req_valid;
  logic [NUM_IN*PORT_W-1:0]  req_port;
  logic [NUM_IN-1:0]         req_head;
  logic [NUM_IN-1:0]         req_tail;
  logic [NUM_OUT-1:0]        credit_ret;
  logic [NUM_IN-1:0]         grant;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT*PORT_W-1:0] out_sel;
  logic                      err;
  logic [NUM_OUT-1:0]        dbg_locked;
  logic [NUM_OUT*CRED_W-1:0] dbg_credit;

  modport master (
    output req_valid, req_port, req_head, req_tail, credit_ret,
    input  grant, out_valid, out_sel, err, dbg_locked, dbg_credit
  );

  modport slave (
    input  req_valid, req_port, req_head, req_tail, credit_ret,
    output grant, out_valid, out_sel, err, dbg_locked, dbg_credit
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, searching upward with wrap.
// Produces a one-hot grant and the winner index; nothing is granted when en=0.
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [PORT_W-1:0] ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt,
  output logic [PORT_W-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = (int'(ptr) + k) % NUM_IN;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PORT_W'(j);
      end
    end
  end
endmodule

// File: rtl/router_switch_alloc.sv
// Switch allocator: per-output round-robin with wormhole lock and downstream
// credit tracking. One rr_arbiter per output; lock, credits and err live here.
module router_switch_alloc
  import router_pkg::*;
(
  input logic            clk,
  input logic            rst,
  router_switch_alloc_if.slave sw
);
  out_state_t          state_q [NUM_OUT];
  out_state_t          state_d [NUM_OUT];
  logic [PORT_W-1:0]   owner_q [NUM_OUT];
  logic [PORT_W-1:0]   owner_d [NUM_OUT];
  logic [PORT_W-1:0]   rr_q    [NUM_OUT];
  logic [PORT_W-1:0]   rr_d    [NUM_OUT];
  logic [CRED_W-1:0]   cred_q  [NUM_OUT];
  logic [CRED_W-1:0]   cred_d  [NUM_OUT];
  logic                err_q, err_d;

  logic [PORT_W-1:0]   port    [NUM_IN];
  logic [NUM_IN-1:0]   arb_req [NUM_OUT];
  logic [NUM_IN-1:0]   arb_gnt [NUM_OUT];
  logic [PORT_W-1:0]   arb_idx [NUM_OUT];
  logic [NUM_OUT-1:0]  arb_en;
  logic [NUM_OUT-1:0]  out_valid_c;
  logic [NUM_IN-1:0]   grant_c;
  logic [NUM_OUT*PORT_W-1:0] out_sel_c;
  logic [NUM_OUT-1:0]  dbg_locked_c;
  logic [NUM_OUT*CRED_W-1:0] dbg_credit_c;

  // Idle outputs accept only head flits; a locked output accepts only its
  // owner's non-head flits, so the owner's next packet waits for the tail.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) port[i] = sw.req_port[i*PORT_W +: PORT_W];
    for (int o = 0; o < NUM_OUT; o++) begin
      arb_req[o] = '0;
      arb_en[o]  = !rst && (cred_q[o] != '0);
      for (int i = 0; i < NUM_IN; i++) begin
        if (sw.req_valid[i] && port[i] == PORT_W'(o)) begin
          if (state_q[o] == IDLE)              arb_req[o][i] = sw.req_head[i];
          else if (owner_q[o] == PORT_W'(i))   arb_req[o][i] = !sw.req_head[i];
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_arb
    rr_arbiter u_arb (
      .req (arb_req[o]),
      .ptr (rr_q[o]),
      .en  (arb_en[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o])
    );
  end

  always_comb begin
    grant_c      = '0;
    out_valid_c  = '0;
    out_sel_c    = '0;
    dbg_locked_c = '0;
    dbg_credit_c = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      out_valid_c[o]                   = |arb_gnt[o];
      grant_c                          = grant_c | arb_gnt[o];
      out_sel_c[o*PORT_W +: PORT_W]    = arb_idx[o];
      dbg_locked_c[o]                  = (state_q[o] == LOCKED);
      dbg_credit_c[o*CRED_W +: CRED_W] = cred_q[o];
    end
  end

  always_comb begin
    err_d = err_q;
    for (int o = 0; o < NUM_OUT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cred_d[o]  = cred_q[o];
      if (out_valid_c[o]) begin
        rr_d[o] = (arb_idx[o] == PORT_W'(NUM_IN - 1)) ? '0 : arb_idx[o] + PORT_W'(1);
        if (state_q[o] == IDLE && !sw.req_tail[arb_idx[o]]) begin
          state_d[o] = LOCKED;
          owner_d[o] = arb_idx[o];
        end else if (state_q[o] == LOCKED && sw.req_tail[arb_idx[o]]) begin
          state_d[o] = IDLE;
        end
      end
      case ({out_valid_c[o], sw.credit_ret[o]})
        2'b10: cred_d[o] = cred_q[o] - CRED_W'(1);
        2'b01: begin
          if (cred_q[o] == CRED_W'(BUF_DEPTH)) err_d = 1'b1;
          else                                 cred_d[o] = cred_q[o] + CRED_W'(1);
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (sw.req_valid[i]) begin
        if (port[i] >= PORT_W'(NUM_OUT))                     err_d = 1'b1;
        else if (!sw.req_head[i] && state_q[port[i]] == IDLE) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cred_q[o]  <= CRED_W'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cred_q[o]  <= cred_d[o];
      end
      err_q <= err_d;
    end
  end

  assign sw.grant      = grant_c;
  assign sw.out_valid  = out_valid_c;
  assign sw.out_sel    = out_sel_c;
  assign sw.err        = err_q & ~rst;
  assign sw.dbg_locked = dbg_locked_c;
  assign sw.dbg_credit = dbg_credit_c;
endmodule

// File: tb/tb_router_switch_alloc.sv
// Bench for router_switch_alloc: directed scenarios plus randomized packet
// traffic, checked against a behavioural per-output allocation model.
module tb_router_switch_alloc;
  import router_pkg::*;

  localparam int SNAP_W = NUM_IN + NUM_OUT + NUM_OUT*PORT_W + 1;

  logic clk = 1'b1;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [NUM_IN-1:0]        v, h, t;
  logic [NUM_IN*PORT_W-1:0] p;
  logic [NUM_OUT-1:0]       ret;

  router_switch_alloc_if sw();
  assign sw.req_valid  = v;
  assign sw.req_head   = h;
  assign sw.req_tail   = t;
  assign sw.req_port   = p;
  assign sw.credit_ret = ret;

  router_switch_alloc dut (.clk(clk), .rst(rst), .sw(sw));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  bit  m_locked [NUM_OUT];
  int  m_owner  [NUM_OUT];
  int  m_rr     [NUM_OUT];
  int  m_cred   [NUM_OUT];
  bit  m_err;
  int  win      [NUM_OUT];
  logic [NUM_IN-1:0]         e_grant;
  logic [NUM_OUT-1:0]        e_ov;
  logic [NUM_OUT*PORT_W-1:0] e_sel;
  logic                      e_err;
  logic [SNAP_W-1:0]         exp_q [$];

  function automatic int port_of(int i);
    return int'(p[i*PORT_W +: PORT_W]);
  endfunction

  function automatic void model_eval();
    int i;
    e_grant = '0; e_ov = '0; e_sel = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      win[o] = -1;
      if (!rst && m_cred[o] > 0) begin
        if (!m_locked[o]) begin
          for (int k = 0; k < NUM_IN; k++) begin
            i = (m_rr[o] + k) % NUM_IN;
            if (win[o] < 0 && v[i] && h[i] && port_of(i) == o) win[o] = i;
          end
        end else begin
          i = m_owner[o];
          if (v[i] && !h[i] && port_of(i) == o) win[o] = i;
        end
      end
      if (win[o] >= 0) begin
        e_grant[win[o]] = 1'b1;
        e_ov[o] = 1'b1;
        e_sel[o*PORT_W +: PORT_W] = PORT_W'(win[o]);
      end
    end
    e_err = rst ? 1'b0 : m_err;
  endfunction

  function automatic void model_commit();
    int pi;
    if (rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_cred[o] = BUF_DEPTH;
      end
      m_err = 0;
      return;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (v[i]) begin
        pi = port_of(i);
        if (pi >= NUM_OUT) m_err = 1;
        else if (!h[i] && !m_locked[pi]) m_err = 1;
      end
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      if (win[o] >= 0) begin
        m_rr[o] = (win[o] + 1) % NUM_IN;
        if (!m_locked[o] && !t[win[o]]) begin
          m_locked[o] = 1; m_owner[o] = win[o];
        end else if (m_locked[o] && t[win[o]]) begin
          m_locked[o] = 0;
        end
      end
      if (win[o] >= 0 && !ret[o]) m_cred[o] = m_cred[o] - 1;
      else if (win[o] < 0 && ret[o]) begin
        if (m_cred[o] == BUF_DEPTH) m_err = 1;
        else m_cred[o] = m_cred[o] + 1;
      end
    end
  endfunction

  function automatic logic [NUM_OUT*CRED_W-1:0] model_cred_vec();
    logic [NUM_OUT*CRED_W-1:0] r;
    for (int o = 0; o < NUM_OUT; o++) r[o*CRED_W +: CRED_W] = CRED_W'(m_cred[o]);
    return r;
  endfunction

  function automatic logic [NUM_OUT-1:0] model_lock_vec();
    logic [NUM_OUT-1:0] r;
    for (int o = 0; o < NUM_OUT; o++) r[o] = m_locked[o];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    v = '0; h = '0; t = '0; p = '0; ret = '0;
  endtask

  task automatic set_req(input int i, input logic vv, input logic hh, input logic tt,
                         input logic [PORT_W-1:0] port);
    v[i] = vv; h[i] = hh; t[i] = tt; p[i*PORT_W +: PORT_W] = port;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    settle();
    advance();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [NUM_OUT*CRED_W-1:0] full;
    full = {NUM_OUT{CRED_W'(BUF_DEPTH)}};
    rst = 1'b1;
    clear_req();
    for (int i = 0; i < NUM_IN; i++) set_req(i, 1'b1, 1'b1, 1'($urandom_range(0, 1)), PORT_W'($urandom_range(0, 4)));
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (sw.grant !== '0 || sw.out_valid !== '0 || sw.out_sel !== '0 || sw.err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got=%b/%b/%h/%b exp=0/0/0/0", sw.grant, sw.out_valid, sw.out_sel, sw.err);
      end
      advance();
    end
    rst = 1'b0;
    clear_req();
    checks++;
    if (sw.dbg_credit !== full) begin
      errors++; $display("FAIL reset_credit got=%h exp=%h", sw.dbg_credit, full);
    end
    checks++;
    if (sw.dbg_locked !== '0 || sw.err !== 1'b0) begin
      errors++; $display("FAIL reset_state got=%b/%b exp=0/0", sw.dbg_locked, sw.err);
    end
  endtask

  task automatic test_round_robin();
    int order [4];
    logic [NUM_IN-1:0] g_exp;
    logic [PORT_W-1:0] s_exp;
    logic [CRED_W-1:0] c_exp;
    order = '{1, 2, 3, 1};
    do_reset();
    for (int i = 1; i <= 3; i++) set_req(i, 1'b1, 1'b1, 1'b1, EAST);
    for (int k = 0; k < 4; k++) begin
      settle();
      g_exp = NUM_IN'(1 << order[k]);
      s_exp = PORT_W'(order[k]);
      checks++;
      if ({sw.grant, sw.out_valid, sw.out_sel, sw.err} !== {e_grant, e_ov, e_sel, e_err}) begin
        errors++; $display("FAIL rr_model got=%b exp=%b", sw.grant, e_grant);
      end
      checks++;
      if (sw.grant !== g_exp || sw.out_sel[EAST*PORT_W +: PORT_W] !== s_exp) begin
        errors++; $display("FAIL rr_order got=%b/%0d exp=%b/%0d", sw.grant, sw.out_sel[EAST*PORT_W +: PORT_W], g_exp, s_exp);
      end
      advance();
      c_exp = CRED_W'(3 - k);
      checks++;
      if (sw.dbg_credit[EAST*CRED_W +: CRED_W] !== c_exp) begin
        errors++; $display("FAIL rr_credit got=%0d exp=%0d", sw.dbg_credit[EAST*CRED_W +: CRED_W], c_exp);
      end
    end
    clear_req();
  endtask

  task automatic test_wormhole();
    logic [NUM_IN-1:0] g_exp [4];
    g_exp = '{5'b00001, 5'b00001, 5'b00001, 5'b10000};
    do_reset();
    set_req(4, 1'b1, 1'b1, 1'b1, NORTH);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_req(0, 1'b1, 1'b1, 1'b0, NORTH);
        1: set_req(0, 1'b1, 1'b0, 1'b0, NORTH);
        2: set_req(0, 1'b1, 1'b0, 1'b1, NORTH);
        default: set_req(0, 1'b0, 1'b0, 1'b0, LOCAL);
      endcase
      settle();
      checks++;
      if ({sw.grant, sw.out_valid, sw.out_sel, sw.err} !== {e_grant, e_ov, e_sel, e_err}) begin
        errors++; $display("FAIL wh_model got=%b exp=%b", sw.grant, e_grant);
      end
      checks++;
      if (sw.grant !== g_exp[k]) begin
        errors++; $display("FAIL wh_grant cycle=%0d got=%b exp=%b", k, sw.grant, g_exp[k]);
      end
      advance();
    end
    clear_req();
  endtask

  task automatic test_credit_stall();
    logic [NUM_IN-1:0] g_tab [9];
    logic              r_tab [9];
    int                c_tab [9];
    g_tab = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00100};
    r_tab = '{0, 0, 0, 0, 0, 1, 0, 1, 1};
    c_tab = '{3, 2, 1, 0, 0, 1, 0, 1, 1};
    do_reset();
    set_req(2, 1'b1, 1'b1, 1'b1, SOUTH);
    for (int k = 0; k < 9; k++) begin
      ret = '0;
      ret[SOUTH] = r_tab[k];
      settle();
      checks++;
      if ({sw.grant, sw.out_valid, sw.out_sel, sw.err} !== {e_grant, e_ov, e_sel, e_err}) begin
        errors++; $display("FAIL cs_model got=%b exp=%b", sw.grant, e_grant);
      end
      checks++;
      if (sw.grant !== g_tab[k]) begin
        errors++; $display("FAIL cs_grant cycle=%0d got=%b exp=%b", k, sw.grant, g_tab[k]);
      end
      advance();
      checks++;
      if (sw.dbg_credit[SOUTH*CRED_W +: CRED_W] !== CRED_W'(c_tab[k])) begin
        errors++; $display("FAIL cs_credit cycle=%0d got=%0d exp=%0d", k, sw.dbg_credit[SOUTH*CRED_W +: CRED_W], c_tab[k]);
      end
    end
    clear_req();
  endtask

  task automatic test_errors();
    // extra credit at full count
    do_reset();
    ret[LOCAL] = 1'b1;
    settle();
    advance();
    ret = '0;
    checks++;
    if (sw.err !== 1'b1 || sw.dbg_credit[LOCAL*CRED_W +: CRED_W] !== CRED_W'(BUF_DEPTH)) begin
      errors++; $display("FAIL err_overflow got=%b/%0d exp=1/%0d", sw.err, sw.dbg_credit[LOCAL*CRED_W +: CRED_W], BUF_DEPTH);
    end
    // out-of-range destination
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b1, 3'd6);
    settle();
    checks++;
    if (sw.grant !== '0 || sw.out_valid !== '0) begin
      errors++; $display("FAIL err_badport_grant got=%b/%b exp=0/0", sw.grant, sw.out_valid);
    end
    advance();
    clear_req();
    checks++;
    if (sw.err !== 1'b1) begin
      errors++; $display("FAIL err_badport got=%b exp=1", sw.err);
    end
    // body flit to an idle output, then stickiness and clear by reset
    do_reset();
    set_req(2, 1'b1, 1'b0, 1'b0, EAST);
    settle();
    checks++;
    if (sw.grant !== '0) begin
      errors++; $display("FAIL err_body_grant got=%b exp=0", sw.grant);
    end
    advance();
    clear_req();
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (sw.err !== 1'b1 || sw.err !== e_err) begin
        errors++; $display("FAIL err_sticky cycle=%0d got=%b exp=1", k, sw.err);
      end
      advance();
    end
    rst = 1'b1;
    settle();
    checks++;
    if (sw.err !== 1'b0) begin
      errors++; $display("FAIL err_in_reset got=%b exp=0", sw.err);
    end
    advance();
    rst = 1'b0;
    checks++;
    if (sw.err !== 1'b0) begin
      errors++; $display("FAIL err_after_reset got=%b exp=0", sw.err);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, WEST);
    settle();
    checks++;
    if (sw.grant !== 5'b00001) begin
      errors++; $display("FAIL rm_head got=%b exp=00001", sw.grant);
    end
    advance();
    set_req(0, 1'b1, 1'b0, 1'b0, WEST);
    rst = 1'b1;
    ret[WEST] = 1'b1;
    settle();
    checks++;
    if (sw.grant !== '0 || sw.out_valid !== '0) begin
      errors++; $display("FAIL rm_in_reset got=%b/%b exp=0/0", sw.grant, sw.out_valid);
    end
    advance();
    rst = 1'b0;
    clear_req();
    set_req(3, 1'b1, 1'b1, 1'b0, WEST);
    settle();
    checks++;
    if (sw.grant !== 5'b01000 || sw.out_sel[WEST*PORT_W +: PORT_W] !== 3'd3) begin
      errors++; $display("FAIL rm_new_owner got=%b/%0d exp=01000/3", sw.grant, sw.out_sel[WEST*PORT_W +: PORT_W]);
    end
    checks++;
    if (sw.dbg_credit[WEST*CRED_W +: CRED_W] !== CRED_W'(BUF_DEPTH) || sw.err !== 1'b0) begin
      errors++; $display("FAIL rm_credit got=%0d/%b exp=%0d/0", sw.dbg_credit[WEST*CRED_W +: CRED_W], sw.err, BUF_DEPTH);
    end
    advance();
    clear_req();
  endtask

  task automatic test_random();
    int pk_left [NUM_IN];
    int pk_dest [NUM_IN];
    bit pk_first [NUM_IN];
    logic [SNAP_W-1:0] got, exp;
    do_reset();
    for (int i = 0; i < NUM_IN; i++) begin pk_left[i] = 0; pk_dest[i] = 0; pk_first[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (pk_left[i] == 0 && $urandom_range(0, 2) == 0) begin
          pk_left[i] = $urandom_range(1, 3);
          pk_dest[i] = $urandom_range(0, NUM_OUT - 1);
          pk_first[i] = 1;
        end
        set_req(i, pk_left[i] > 0, pk_first[i], pk_left[i] == 1, PORT_W'(pk_dest[i]));
      end
      for (int o = 0; o < NUM_OUT; o++)
        ret[o] = (m_cred[o] < BUF_DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      settle();
      exp_q.push_back({e_grant, e_ov, e_sel, e_err});
      got = {sw.grant, sw.out_valid, sw.out_sel, sw.err};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_outputs cycle=%0d got=%h exp=%h", c, got, exp);
      end
      advance();
      checks++;
      if (sw.dbg_credit !== model_cred_vec() || sw.dbg_locked !== model_lock_vec()) begin
        errors++; $display("FAIL rand_state cycle=%0d got=%h/%b exp=%h/%b", c, sw.dbg_credit, sw.dbg_locked, model_cred_vec(), model_lock_vec());
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (e_grant[i]) begin
          pk_left[i] = pk_left[i] - 1;
          pk_first[i] = 0;
        end
      end
    end
    clear_req();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_req();
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_errors();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
